// File: rtl/string_hw_pkg.sv
// Shared types and constants for the String_HW engine and its request scheduler.
package string_hw_pkg;

   localparam int MAX_BLOCKS = 2;

   typedef enum logic [3:0] {
      STR_CMP    = 4'd0,
      STR_UPPER  = 4'd1,
      STR_LOWER  = 4'd2,
      STR_REV    = 4'd3,
      STR_SEARCH = 4'd4
   } str_op_e;

   localparam logic [3:0] STR_OP_MAX       = 4'd4;
   localparam logic [7:0] SEARCH_NOT_FOUND = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } sched_state_e;

   // The engine has no decode for anything past SEARCH and would never raise done.
   function automatic logic op_is_valid(input logic [3:0] op);
      return op <= STR_OP_MAX;
   endfunction

endpackage

// File: rtl/string_hw_sched_rr_arbiter.sv
// Round-robin pick: combinational winner from req + pointer; pointer moves to owner+1 on adv_i.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req_i,
   input  logic            adv_i,
   input  logic [PW-1:0]   owner_i,
   output logic            any_o,
   output logic [PW-1:0]   pick_idx_o,
   output logic [NREQ-1:0] pick_oh_o
);

   logic [PW-1:0] ptr_q, ptr_d;

   always_comb begin
      int idx;
      idx        = 0;
      any_o      = 1'b0;
      pick_idx_o = '0;
      // Scan farthest-first so the requester closest to the pointer overwrites the rest.
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (req_i[idx]) begin
            any_o      = 1'b1;
            pick_idx_o = PW'(idx);
         end
      end
      pick_oh_o = any_o ? (NREQ'(1) << pick_idx_o) : '0;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) begin
         ptr_d = (owner_i == PW'(NREQ - 1)) ? '0 : PW'(owner_i + 1'b1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/string_hw_sched.sv
// Shares one String_HW engine between NREQ requesters: RR grant, command latch, go/done handshake.
// Optional BUSY watchdog with engine reset is built when STRHW_TIMEOUT_EN is defined.
module string_hw_sched
   import string_hw_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int MAX_BLOCKS     = string_hw_pkg::MAX_BLOCKS,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NREQ-1:0]                      req,
   input  logic [NREQ-1:0][3:0]                 req_index,
   input  logic [NREQ-1:0][7:0]                 req_length,
   input  logic [NREQ-1:0][MAX_BLOCKS*32-1:0]   req_A,
   input  logic [NREQ-1:0][MAX_BLOCKS*32-1:0]   req_B,
   output logic [NREQ-1:0]                      gnt,
   output logic [NREQ-1:0]                      rsp_valid,
   output logic [MAX_BLOCKS*32-1:0]             rsp_result,
   output logic                                 rsp_err,
   output logic                                 eng_go,
   output logic [3:0]                           eng_index,
   output logic [7:0]                           eng_length,
   output logic [MAX_BLOCKS*32-1:0]             eng_A,
   output logic [MAX_BLOCKS*32-1:0]             eng_B,
   output logic                                 eng_reset,
   input  logic                                 eng_done,
   input  logic [MAX_BLOCKS*32-1:0]             eng_result
);

   localparam int DW = MAX_BLOCKS * 32;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   sched_state_e      state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [PW-1:0]     owner_q, owner_d;
   logic              inv_q, inv_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]     rsp_result_q, rsp_result_d;
   logic              rsp_err_q, rsp_err_d;
   logic              go_q, go_d;
   logic [3:0]        idx_q, idx_d;
   logic [7:0]        len_q, len_d;
   logic [DW-1:0]     a_q, a_d, b_q, b_d;
   logic              adv;
   logic              any;
   logic [PW-1:0]     pick_idx;
   logic [NREQ-1:0]   pick_oh;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk        (clk),
      .reset      (reset),
      .req_i      (req),
      .adv_i      (adv),
      .owner_i    (owner_q),
      .any_o      (any),
      .pick_idx_o (pick_idx),
      .pick_oh_o  (pick_oh)
   );

`ifdef STRHW_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          eng_reset_q, eng_reset_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         eng_reset_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         eng_reset_q <= eng_reset_d;
      end
   end

   assign eng_reset = eng_reset_q;
`else
   assign eng_reset = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      owner_d      = owner_q;
      inv_d        = inv_q;
      rsp_valid_d  = '0;
      rsp_err_d    = 1'b0;
      rsp_result_d = rsp_result_q;
      go_d         = go_q;
      idx_d        = idx_q;
      len_d        = len_q;
      a_d          = a_q;
      b_d          = b_q;
      adv          = 1'b0;
`ifdef STRHW_TIMEOUT_EN
      cnt_d        = cnt_q;
      eng_reset_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (inv_q) begin
               rsp_valid_d  = gnt_q;
               rsp_err_d    = 1'b1;
               rsp_result_d = '0;
               gnt_d        = '0;
               inv_d        = 1'b0;
               adv          = 1'b1;
            // While a rejection is being reported the owner's req is still legally high.
            end else if (any && (rsp_valid_q == '0)) begin
               owner_d = pick_idx;
               gnt_d   = pick_oh;
               idx_d   = req_index[pick_idx];
               len_d   = req_length[pick_idx];
               a_d     = req_A[pick_idx];
               b_d     = req_B[pick_idx];
               if (!op_is_valid(req_index[pick_idx])) begin
                  inv_d = 1'b1;
               end else begin
                  go_d    = 1'b1;
                  state_d = BUSY;
`ifdef STRHW_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         BUSY: begin
            if (eng_done) begin
               rsp_result_d = eng_result;
               rsp_valid_d  = gnt_q;
               go_d         = 1'b0;
               gnt_d        = '0;
               adv          = 1'b1;
               state_d      = DRAIN;
            end
`ifdef STRHW_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               rsp_result_d = '0;
               rsp_valid_d  = gnt_q;
               rsp_err_d    = 1'b1;
               go_d         = 1'b0;
               gnt_d        = '0;
               eng_reset_d  = 1'b1;
               adv          = 1'b1;
               state_d      = DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DRAIN: begin
            // Engine holds done until it sees go low; re-arming before that would skip a command.
            gnt_d = '0;
            if (!eng_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = DRAIN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= DRAIN;
         gnt_q        <= '0;
         owner_q      <= '0;
         inv_q        <= 1'b0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
         go_q         <= 1'b0;
         idx_q        <= '0;
         len_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         owner_q      <= owner_d;
         inv_q        <= inv_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
         go_q         <= go_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         a_q          <= a_d;
         b_q          <= b_d;
      end
   end

   assign gnt        = gnt_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_err    = rsp_err_q;
   assign eng_go     = go_q;
   assign eng_index  = idx_q;
   assign eng_length = len_q;
   assign eng_A      = a_q;
   assign eng_B      = b_q;

endmodule

// File: tb/tb_string_hw_sched.sv
// Bench for string_hw_sched: behavioural string engine, requester agents and a scoreboard.
module tb_string_hw_sched;

   localparam int NREQ = 2;
   localparam int NB   = 8;
   localparam int DW   = NB * 8;
`ifdef STRHW_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 64;
`endif

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NREQ-1:0]         req;
   logic [NREQ-1:0][3:0]    req_index;
   logic [NREQ-1:0][7:0]    req_length;
   logic [NREQ-1:0][DW-1:0] req_A, req_B;
   logic [NREQ-1:0]         gnt, rsp_valid;
   logic [DW-1:0]           rsp_result;
   logic                    rsp_err, eng_go, eng_reset, eng_done;
   logic [3:0]              eng_index;
   logic [7:0]              eng_length;
   logic [DW-1:0]           eng_A, eng_B, eng_result;

   string_hw_sched #(.NREQ(NREQ), .MAX_BLOCKS(2), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_index(req_index), .req_length(req_length),
      .req_A(req_A), .req_B(req_B), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .rsp_err(rsp_err), .eng_go(eng_go), .eng_index(eng_index), .eng_length(eng_length),
      .eng_A(eng_A), .eng_B(eng_B), .eng_reset(eng_reset), .eng_done(eng_done),
      .eng_result(eng_result)
   );

   initial forever #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   // scoreboard / model state
   int ptr, owner, n_rsp, auto_pct;
   int grant_log[$];
   logic [3:0]    c_idx[NREQ];
   logic [7:0]    c_len[NREQ];
   logic [DW-1:0] c_a[NREQ], c_b[NREQ];
   logic [NREQ-1:0] drop_pend, gnt_prev;
   logic [DW-1:0] last_result;
   logic          last_err;
   // engine model state
   int   eng_mode; // 0 normal, 1 never done, 2 done stuck high
   int   lat, hold;
   bit   go_prev, go_seen;
   logic [139:0] snap;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] a_chr(input logic [DW-1:0] s, input int k);
      return s[DW-1-8*k -: 8];
   endfunction

   // Behavioural String_HW: what the engine would compute for a command.
   function automatic logic [DW-1:0] eng_fn(input logic [3:0] op, input logic [7:0] len,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      logic [7:0] c;
      bit ok;
      r = '0;
      case (op)
         4'd0: r = (a == b) ? DW'(1) : DW'(0);
         4'd1, 4'd2: for (int k = 0; k < NB; k++) begin
            c = a[8*k +: 8];
            if (op == 4'd1 && c >= 8'h61 && c <= 8'h7a) c = c - 8'd32;
            if (op == 4'd2 && c >= 8'h41 && c <= 8'h5a) c = c + 8'd32;
            r[8*k +: 8] = c;
         end
         4'd3: for (int k = 0; k < NB; k++) r[8*k +: 8] = a[8*(NB-1-k) +: 8];
         4'd4: begin
            r = DW'(8'hFF);
            if (len >= 1 && int'(len) <= NB) begin
               for (int p = NB - int'(len); p >= 0; p--) begin
                  ok = 1'b1;
                  for (int j = 0; j < int'(len); j++)
                     if (a_chr(a, p + j) != b[8*(int'(len)-1-j) +: 8]) ok = 1'b0;
                  if (ok) r = DW'(p);
               end
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_str();
      logic [DW-1:0] s;
      s = '0;
      for (int k = 0; k < NB; k++)
         s[8*k +: 8] = (($urandom_range(0, 1) == 1) ? 8'h61 : 8'h41) + 8'($urandom_range(0, 25));
      return s;
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++)
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   task automatic issue(input int i, input logic [3:0] op, input logic [7:0] len,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
      c_idx[i] = op; c_len[i] = len; c_a[i] = a; c_b[i] = b;
      req_index[i] = op; req_length[i] = len; req_A[i] = a; req_B[i] = b;
      req[i] = 1'b1;
   endtask

   task automatic issue_random(input int i);
      logic [3:0] op;
      logic [DW-1:0] a, b;
      logic [7:0] len;
      op  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      a   = rand_str();
      b   = rand_str();
      len = 8'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) b = (op == 4'd0) ? a : DW'(a[8*$urandom_range(0, 5) +: 24]);
      issue(i, op, len, a, b);
   endtask

   // One clock: observe at the falling edge, score, then drive engine and requesters.
   task automatic cycle();
      logic [NREQ-1:0] drop_now;
      logic exp_err;
      int w;
      @(negedge clk);
      drop_now = drop_pend;
      if (!reset) begin
         if (eng_go && !go_prev) begin
            go_seen = 1'b1;
            chk("go_rise_done_low", eng_done, 0);
            snap = {eng_index, eng_length, eng_A, eng_B};
            lat  = $urandom_range(1, 4);
         end else if (eng_go) begin
            chk("eng_cmd_stable", {eng_index, eng_length, eng_A, eng_B}, snap);
         end
         if (gnt != '0 && gnt_prev == '0) begin
            w = rr_pick(req);
            chk("gnt_winner", gnt, (w < 0) ? 0 : (1 << w));
            owner = w;
            grant_log.push_back(w);
         end
         if (rsp_valid != '0) begin
            exp_err = (c_idx[owner] > 4'd4) || (eng_mode == 1);
            chk("rsp_owner", rsp_valid, 1 << owner);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_result", rsp_result,
                exp_err ? '0 : eng_fn(c_idx[owner], c_len[owner], c_a[owner], c_b[owner]));
            last_result = rsp_result;
            last_err    = rsp_err;
            n_rsp++;
            drop_pend[owner] = 1'b1;
            ptr = (owner + 1) % NREQ;
         end
      end
      gnt_prev = gnt;
      go_prev  = eng_go;
      if (eng_mode == 2) eng_done = 1'b1;
      else if (eng_reset) eng_done = 1'b0;
      else if (eng_go && !eng_done) begin
         if (eng_mode == 0) begin
            if (lat <= 1) begin
               eng_done   = 1'b1;
               eng_result = eng_fn(eng_index, eng_length, eng_A, eng_B);
               hold       = $urandom_range(0, 2);
            end else lat--;
         end
      end else if (!eng_go && eng_done) begin
         if (hold == 0) eng_done = 1'b0;
         else hold--;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (drop_now[i]) begin
            req[i] = 1'b0;
            drop_pend[i] = 1'b0;
         end else if (!req[i] && !drop_pend[i] && auto_pct > 0 &&
                      $urandom_range(0, 99) < auto_pct) begin
            issue_random(i);
         end
      end
   endtask

   task automatic run_until_rsp(input string tag, input int n, input int budget);
      int start, c;
      start = n_rsp;
      c = 0;
      while (n_rsp - start < n && c < budget) begin
         cycle();
         c++;
      end
      chk(tag, (n_rsp - start) >= n, 1);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      req = '0; drop_pend = '0; ptr = 0; gnt_prev = '0; go_prev = 1'b0; lat = 0; hold = 0;
      #1;
      chk("reset_outputs", {gnt, rsp_valid, rsp_err, eng_go, eng_reset, rsp_result,
                            eng_index, eng_length, eng_A, eng_B}, '0);
      repeat (2) cycle();
      reset = 1'b0;
   endtask

   initial begin
      int c, gcnt;
      bit seen;
      reset = 1'b0; req = '0; req_index = '0; req_length = '0; req_A = '0; req_B = '0;
      eng_done = 1'b0; eng_result = '0; eng_mode = 0; auto_pct = 0; n_rsp = 0; owner = 0;
      go_seen = 1'b0; snap = '0; last_result = '0; last_err = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         c_idx[i] = '0; c_len[i] = '0; c_a[i] = '0; c_b[i] = '0;
      end
      #2;
      apply_reset();
      repeat (2) cycle();

      // Single CMP of identical strings
      issue(0, 4'd0, 8'd0, "abcdefgh", "abcdefgh");
      cycle();
      chk("single_gnt", gnt, 2'b01);
      chk("single_go", eng_go, 1);
      run_until_rsp("single_rsp_seen", 1, 30);
      chk("single_result", last_result, 1);
      chk("single_err", last_err, 0);
      repeat (6) cycle();

      // Invalid opcode from requester 1: rejected without dispatch
      go_seen = 1'b0;
      issue(1, 4'd9, 8'd0, rand_str(), rand_str());
      cycle();
      chk("inv_gnt", gnt, 2'b10);
      cycle();
      chk("inv_rsp_valid", rsp_valid, 2'b10);
      chk("inv_rsp_err", rsp_err, 1);
      repeat (6) cycle();
      chk("inv_no_go", go_seen, 0);

      // Search
      issue(0, 4'd4, 8'd3, "xxabcxxx", "abc");
      run_until_rsp("search_rsp_seen", 1, 30);
      chk("search_result", last_result, 2);
      chk("search_err", last_err, 0);
      repeat (6) cycle();

      // Contention after reset: both held, requester 0 wins first
      apply_reset();
      grant_log.delete();
      issue(0, 4'd1, 8'd0, rand_str(), rand_str());
      issue(1, 4'd3, 8'd0, rand_str(), rand_str());
      auto_pct = 100;
      run_until_rsp("cont_rsp_seen", 4, 80);
      auto_pct = 0;
      chk("cont_order0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
      chk("cont_order1", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
      chk("cont_order2", (grant_log.size() > 2) ? grant_log[2] : -1, 0);
      chk("cont_order3", (grant_log.size() > 3) ? grant_log[3] : -1, 1);

      // Random traffic
      auto_pct = 30;
      repeat (500) cycle();
      auto_pct = 0;
      c = 0;
      while ((req != '0 || eng_go || gnt != '0) && c < 200) begin
         cycle();
         c++;
      end
      chk("random_drained", {req, gnt, eng_go}, 0);
      repeat (6) cycle();

      // Reset while the engine holds done
      issue(0, 4'd3, 8'd0, rand_str(), rand_str());
      c = 0;
      while (!eng_done && c < 20) begin
         cycle();
         c++;
      end
      chk("mid_busy_done_up", eng_done, 1);
      eng_mode = 2;
      apply_reset();
      issue(0, 4'd2, 8'd0, rand_str(), rand_str());
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("stuck_done_no_gnt", {gnt, eng_go}, 0);
      end
      eng_mode = 0;
      eng_done = 1'b0;
      run_until_rsp("recover_rsp_seen", 1, 30);
      chk("recover_err", last_err, 0);
      repeat (6) cycle();

`ifdef STRHW_TIMEOUT_EN
      // Engine never completes: watchdog fires after TO BUSY cycles
      eng_mode = 1;
      issue(0, 4'd0, 8'd0, rand_str(), rand_str());
      gcnt = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         cycle();
         if (eng_go) gcnt++;
         if (eng_reset) seen = 1'b1;
      end
      chk("to_reset_seen", seen, 1);
      chk("to_busy_cycles", gcnt, TO);
      chk("to_err", last_err, 1);
      chk("to_result", last_result, 0);
      cycle();
      chk("to_reset_pulse", eng_reset, 0);
      eng_mode = 0;
      repeat (6) cycle();
      issue(1, 4'd3, 8'd0, rand_str(), rand_str());
      run_until_rsp("to_next_rsp_seen", 1, 30);
      chk("to_next_err", last_err, 0);
`else
      gcnt = 0;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         if (eng_reset) seen = 1'b1;
         gcnt++;
      end
      chk("eng_reset_tied_low", seen, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
